// File: rtl/leve1_trap_seq_if.sv
// Signal bundle between the trap/xRET sequencer and its surroundings:
// the pipeline request/return handshakes, CSR snapshots, and the CSR write port.
interface leve1_trap_seq_if #(
  parameter int XLEN = 64
);
  logic            TRAP_REQ;
  logic [XLEN-1:0] TRAP_CAUSE;
  logic [XLEN-1:0] TRAP_EPC;
  logic [XLEN-1:0] TRAP_TVAL;
  logic            TRAP_ACK;
  logic [1:0]      RET_REQ;
  logic            RET_ACK;
  logic [XLEN-1:0] MSTATUS;
  logic [XLEN-1:0] MEDELEG;
  logic [XLEN-1:0] MTVEC;
  logic [XLEN-1:0] STVEC;
  logic [XLEN-1:0] MEPC;
  logic [XLEN-1:0] SEPC;
  logic [1:0]      PIPE_WCMD;
  logic [11:0]     PIPE_WA;
  logic [XLEN-1:0] PIPE_WD;
  logic            PIPE_WREADY;
  logic [1:0]      CSR_WCMD;
  logic [11:0]     CSR_WA;
  logic [XLEN-1:0] CSR_WD;
  logic [1:0]      MODE;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            BUSY;

  modport slave (
    input  TRAP_REQ, TRAP_CAUSE, TRAP_EPC, TRAP_TVAL, RET_REQ,
    input  MSTATUS, MEDELEG, MTVEC, STVEC, MEPC, SEPC,
    input  PIPE_WCMD, PIPE_WA, PIPE_WD,
    output TRAP_ACK, RET_ACK, PIPE_WREADY, CSR_WCMD, CSR_WA, CSR_WD,
    output MODE, REDIRECT, REDIRECT_PC, BUSY
  );

  modport master (
    output TRAP_REQ, TRAP_CAUSE, TRAP_EPC, TRAP_TVAL, RET_REQ,
    output MSTATUS, MEDELEG, MTVEC, STVEC, MEPC, SEPC,
    output PIPE_WCMD, PIPE_WA, PIPE_WD,
    input  TRAP_ACK, RET_ACK, PIPE_WREADY, CSR_WCMD, CSR_WA, CSR_WD,
    input  MODE, REDIRECT, REDIRECT_PC, BUSY
  );
endinterface

// File: rtl/leve1_trap_seq.sv
// Trap-entry / xRET sequencer: owns the privilege mode and arbitrates the single
// CSR write port between pipeline CSR writes and its own multi-cycle sequences.
module leve1_trap_seq #(
  parameter int XLEN = 64
) (
  input logic              CLK,
  input logic              RST,
  leve1_trap_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STAT,
    R_STAT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] stat_q, stat_d;
  logic [XLEN-1:0] pc_q, pc_d;
  // For traps: target is S. For returns: request is SRET.
  logic            to_s_q, to_s_d;

  logic [XLEN-1:0] stat_new;
  logic            trap_ack, ret_ack, pipe_wready, redirect;
  logic [1:0]      wcmd;
  logic [11:0]     wa;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] redirect_pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      mode_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_ff @(posedge CLK) begin
    cause_q <= cause_d;
    epc_q   <= epc_d;
    tval_q  <= tval_d;
    stat_q  <= stat_d;
    pc_q    <= pc_d;
    to_s_q  <= to_s_d;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    tval_d      = tval_q;
    stat_d      = stat_q;
    pc_d        = pc_q;
    to_s_d      = to_s_q;
    stat_new    = stat_q;
    trap_ack    = 1'b0;
    ret_ack     = 1'b0;
    pipe_wready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    wcmd        = 2'b00;
    wa          = '0;
    wd          = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.TRAP_REQ) begin
          trap_ack = 1'b1;
          to_s_d   = (mode_q != 2'b11) && bus.MEDELEG[bus.TRAP_CAUSE[5:0]];
          cause_d  = bus.TRAP_CAUSE;
          epc_d    = bus.TRAP_EPC;
          tval_d   = bus.TRAP_TVAL;
          stat_d   = bus.MSTATUS;
          pc_d     = to_s_d ? bus.STVEC : bus.MTVEC;
          state_d  = T_EPC;
        end else if (bus.RET_REQ != 2'b00) begin
          ret_ack  = 1'b1;
          to_s_d   = (bus.RET_REQ == 2'b01);
          stat_d   = bus.MSTATUS;
          pc_d     = to_s_d ? bus.SEPC : bus.MEPC;
          state_d  = R_STAT;
        end else begin
          pipe_wready = 1'b1;
          wcmd        = bus.PIPE_WCMD;
          wa          = bus.PIPE_WA;
          wd          = bus.PIPE_WD;
        end
      end
      T_EPC: begin
        wcmd    = 2'b01;
        wa      = to_s_q ? 12'h141 : 12'h341;
        wd      = epc_q;
        state_d = T_CAUSE;
      end
      T_CAUSE: begin
        wcmd    = 2'b01;
        wa      = to_s_q ? 12'h142 : 12'h342;
        wd      = cause_q;
        state_d = T_TVAL;
      end
      T_TVAL: begin
        wcmd    = 2'b01;
        wa      = to_s_q ? 12'h143 : 12'h343;
        wd      = tval_q;
        state_d = T_STAT;
      end
      T_STAT: begin
        if (to_s_q) begin
          stat_new[5] = stat_q[1];
          stat_new[1] = 1'b0;
          stat_new[8] = mode_q[0];
          wa          = 12'h100;
          mode_d      = 2'b01;
        end else begin
          stat_new[7]     = stat_q[3];
          stat_new[3]     = 1'b0;
          stat_new[12:11] = mode_q;
          wa              = 12'h300;
          mode_d          = 2'b11;
        end
        wcmd        = 2'b01;
        wd          = stat_new;
        redirect    = 1'b1;
        redirect_pc = {pc_q[XLEN-1:2], 2'b00};
        state_d     = IDLE;
      end
      R_STAT: begin
        if (to_s_q) begin
          stat_new[1] = stat_q[5];
          stat_new[5] = 1'b1;
          stat_new[8] = 1'b0;
          wa          = 12'h100;
          mode_d      = {1'b0, stat_q[8]};
        end else begin
          stat_new[3]     = stat_q[7];
          stat_new[7]     = 1'b1;
          stat_new[12:11] = 2'b00;
          wa              = 12'h300;
          mode_d          = stat_q[12:11];
        end
        wcmd        = 2'b01;
        wd          = stat_new;
        redirect    = 1'b1;
        redirect_pc = pc_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset aborts immediately: no handshakes, no writes, no redirect.
    if (RST) begin
      trap_ack    = 1'b0;
      ret_ack     = 1'b0;
      pipe_wready = 1'b0;
      redirect    = 1'b0;
      wcmd        = 2'b00;
    end
  end

  assign bus.TRAP_ACK    = trap_ack;
  assign bus.RET_ACK     = ret_ack;
  assign bus.PIPE_WREADY = pipe_wready;
  assign bus.CSR_WCMD    = wcmd;
  assign bus.CSR_WA      = wa;
  assign bus.CSR_WD      = wd;
  assign bus.MODE        = mode_q;
  assign bus.REDIRECT    = redirect;
  assign bus.REDIRECT_PC = redirect_pc;
  assign bus.BUSY        = (state_q != IDLE) && !RST;

endmodule

// File: tb/tb_leve1_trap_seq.sv
// Scoreboard bench for leve1_trap_seq: expected CSR writes and redirects are queued
// when stimulus is driven and popped by a negedge monitor as the DUT produces them.
module tb_leve1_trap_seq;
  localparam int XLEN = 64;

  typedef struct packed {
    logic [11:0] wa;
    logic [63:0] wd;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  wr_t         wq[$];
  logic [63:0] rq[$];

  leve1_trap_seq_if #(.XLEN(XLEN)) bus ();

  leve1_trap_seq #(.XLEN(XLEN)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every CSR write and redirect the DUT emits must match the head of its queue.
  always @(negedge clk) begin
    wr_t         e;
    logic [63:0] p;
    if (bus.CSR_WCMD == 2'b01) begin
      if (wq.size() == 0) check_output("wr_pending", 64'(wq.size()), 64'd1);
      else begin
        e = wq.pop_front();
        check_output("wr_addr", {52'd0, bus.CSR_WA}, {52'd0, e.wa});
        check_output("wr_data", bus.CSR_WD, e.wd);
      end
    end
    if (bus.REDIRECT) begin
      if (rq.size() == 0) check_output("redir_pending", 64'(rq.size()), 64'd1);
      else begin
        p = rq.pop_front();
        check_output("redir_pc", bus.REDIRECT_PC, p);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_trap(input logic [63:0] cause, input logic [63:0] epc,
                                     input logic [63:0] tval, input logic [63:0] mstatus,
                                     input logic is_s, input logic [63:0] stat_exp,
                                     input logic [63:0] pc_exp, input logic [1:0] mode_exp);
    logic [11:0] base;
    base = is_s ? 12'h140 : 12'h340;
    wq.push_back('{wa: base + 12'd1, wd: epc});
    wq.push_back('{wa: base + 12'd2, wd: cause});
    wq.push_back('{wa: base + 12'd3, wd: tval});
    wq.push_back('{wa: is_s ? 12'h100 : 12'h300, wd: stat_exp});
    rq.push_back(pc_exp);
    bus.TRAP_REQ   = 1'b1;
    bus.TRAP_CAUSE = cause;
    bus.TRAP_EPC   = epc;
    bus.TRAP_TVAL  = tval;
    bus.MSTATUS    = mstatus;
    @(negedge clk);
    check_output("trap_ack", 64'(bus.TRAP_ACK), 64'd1);
    check_output("trap_wready", 64'(bus.PIPE_WREADY), 64'd0);
    step();
    bus.TRAP_REQ = 1'b0;
    bus.MSTATUS  = ~mstatus;
    repeat (3) @(negedge clk);
    check_output("trap_redir_early", 64'(bus.REDIRECT), 64'd0);
    @(negedge clk);
    check_output("trap_redir_t4", 64'(bus.REDIRECT), 64'd1);
    check_output("trap_busy", 64'(bus.BUSY), 64'd1);
    step();
    check_output("trap_mode", 64'(bus.MODE), 64'(mode_exp));
    check_output("trap_idle", 64'(bus.BUSY), 64'd0);
  endtask

  task automatic apply_stimulus_ret(input logic [1:0] kind, input logic [63:0] mstatus,
                                    input logic [63:0] mepc, input logic [63:0] sepc,
                                    input logic [63:0] stat_exp, input logic [63:0] pc_exp,
                                    input logic [1:0] mode_exp);
    wq.push_back('{wa: (kind == 2'b11) ? 12'h300 : 12'h100, wd: stat_exp});
    rq.push_back(pc_exp);
    bus.RET_REQ = kind;
    bus.MSTATUS = mstatus;
    bus.MEPC    = mepc;
    bus.SEPC    = sepc;
    @(negedge clk);
    check_output("ret_ack", 64'(bus.RET_ACK), 64'd1);
    step();
    bus.RET_REQ = 2'b00;
    bus.MSTATUS = ~mstatus;
    @(negedge clk);
    check_output("ret_redir_t1", 64'(bus.REDIRECT), 64'd1);
    step();
    check_output("ret_mode", 64'(bus.MODE), 64'(mode_exp));
    check_output("ret_idle", 64'(bus.BUSY), 64'd0);
  endtask

  initial begin
    bus.TRAP_REQ   = 1'b0;
    bus.TRAP_CAUSE = '0;
    bus.TRAP_EPC   = '0;
    bus.TRAP_TVAL  = '0;
    bus.RET_REQ    = 2'b00;
    bus.MSTATUS    = '0;
    bus.MEDELEG    = '0;
    bus.MTVEC      = 64'h8000_0003;
    bus.STVEC      = 64'h8020_0000;
    bus.MEPC       = '0;
    bus.SEPC       = '0;
    bus.PIPE_WCMD  = 2'b01;
    bus.PIPE_WA    = 12'h007;
    bus.PIPE_WD    = 64'h9;

    // Reset: pipeline write held off, M mode.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_wready", 64'(bus.PIPE_WREADY), 64'd0);
    check_output("rst_wcmd", 64'(bus.CSR_WCMD), 64'd0);
    check_output("rst_busy", 64'(bus.BUSY), 64'd0);
    check_output("rst_mode", 64'(bus.MODE), 64'd3);
    step();
    rst = 1'b0;

    // Idle pass-through of a pipeline write.
    wq.push_back('{wa: 12'h305, wd: 64'h1234});
    bus.PIPE_WA = 12'h305;
    bus.PIPE_WD = 64'h1234;
    @(negedge clk);
    check_output("idle_wready", 64'(bus.PIPE_WREADY), 64'd1);
    step();
    bus.PIPE_WCMD = 2'b00;

    apply_stimulus_trap(64'd2, 64'h8000_0100, 64'hDEAD, 64'h8, 1'b0, 64'h1880, 64'h8000_0000, 2'b11);
    apply_stimulus_ret(2'b11, 64'h0, 64'h1000, 64'h0, 64'h80, 64'h1000, 2'b00);
    bus.MEDELEG = 64'h100;
    apply_stimulus_trap(64'd8, 64'h2000, 64'h0, 64'h2, 1'b1, 64'h20, 64'h8020_0000, 2'b01);
    bus.MEDELEG = 64'h0;
    bus.MTVEC   = 64'h8000_0401;
    apply_stimulus_trap(64'd8, 64'h3000, 64'h55, 64'h22, 1'b0, 64'h822, 64'h8000_0400, 2'b11);
    apply_stimulus_ret(2'b11, 64'h880, 64'h8020_1000, 64'h0, 64'h88, 64'h8020_1000, 2'b01);

    // Trap, SRET and pipeline write all presented together.
    wq.push_back('{wa: 12'h341, wd: 64'h6000});
    wq.push_back('{wa: 12'h342, wd: 64'd2});
    wq.push_back('{wa: 12'h343, wd: 64'h66});
    wq.push_back('{wa: 12'h300, wd: 64'h800});
    rq.push_back(64'h8000_0400);
    wq.push_back('{wa: 12'h100, wd: 64'h22});
    rq.push_back(64'h4000);
    wq.push_back('{wa: 12'h123, wd: 64'hABC});
    bus.TRAP_REQ   = 1'b1;
    bus.TRAP_CAUSE = 64'd2;
    bus.TRAP_EPC   = 64'h6000;
    bus.TRAP_TVAL  = 64'h66;
    bus.MSTATUS    = 64'h0;
    bus.RET_REQ    = 2'b01;
    bus.SEPC       = 64'h4000;
    bus.PIPE_WCMD  = 2'b01;
    bus.PIPE_WA    = 12'h123;
    bus.PIPE_WD    = 64'hABC;
    @(negedge clk);
    check_output("sim_trap_ack", 64'(bus.TRAP_ACK), 64'd1);
    check_output("sim_ret_ack_t0", 64'(bus.RET_ACK), 64'd0);
    check_output("sim_wready_t0", 64'(bus.PIPE_WREADY), 64'd0);
    step();
    bus.TRAP_REQ = 1'b0;
    bus.MSTATUS  = 64'h120;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_output($sformatf("sim_wready_t%0d", i), 64'(bus.PIPE_WREADY), 64'd0);
      check_output($sformatf("sim_ret_ack_t%0d", i), 64'(bus.RET_ACK), 64'd0);
    end
    check_output("sim_trap_redir", 64'(bus.REDIRECT), 64'd1);
    @(negedge clk);
    check_output("sim_mode_m", 64'(bus.MODE), 64'd3);
    check_output("sim_sret_ack", 64'(bus.RET_ACK), 64'd1);
    check_output("sim_wready_t5", 64'(bus.PIPE_WREADY), 64'd0);
    step();
    bus.RET_REQ = 2'b00;
    @(negedge clk);
    check_output("sim_sret_redir", 64'(bus.REDIRECT), 64'd1);
    check_output("sim_wready_t6", 64'(bus.PIPE_WREADY), 64'd0);
    @(negedge clk);
    check_output("sim_wready_t7", 64'(bus.PIPE_WREADY), 64'd1);
    check_output("sim_mode_s", 64'(bus.MODE), 64'd1);
    step();
    bus.PIPE_WCMD = 2'b00;

    // Reset while the cause write is due aborts the sequence.
    wq.push_back('{wa: 12'h341, wd: 64'h5000});
    bus.TRAP_REQ   = 1'b1;
    bus.TRAP_EPC   = 64'h5000;
    bus.TRAP_TVAL  = 64'h77;
    @(negedge clk);
    check_output("abort_ack", 64'(bus.TRAP_ACK), 64'd1);
    step();
    bus.TRAP_REQ = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_wcmd", 64'(bus.CSR_WCMD), 64'd0);
    check_output("abort_redir", 64'(bus.REDIRECT), 64'd0);
    step();
    rst = 1'b0;
    check_output("abort_busy", 64'(bus.BUSY), 64'd0);
    check_output("abort_mode", 64'(bus.MODE), 64'd3);
    repeat (5) @(negedge clk);

    check_output("wq_drained", 64'(wq.size()), 64'd0);
    check_output("rq_drained", 64'(rq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/leve1_trap_seq.md
Name: leve1_trap_seq

Overview:
- Trap-entry and xRET sequencer in front of the single CSR write port (CSR_WCMD/CSR_WA/CSR_WD) of the LEVE1 CSR file.
- Arbitrates that port between the pipeline's CSR-instruction writes and its own multi-cycle trap/return write sequences.
- Owns the current privilege mode.
- Issues a one-cycle PC redirect at the end of each sequence.

Parameters:
- XLEN, 64, data/CSR width; MXLEN equals XLEN.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- TRAP_REQ  in  1  exception request; held until TRAP_ACK.
- TRAP_CAUSE  in  XLEN  exception code; bit XLEN-1 is always 0 (exceptions only).
- TRAP_EPC  in  XLEN  faulting PC.
- TRAP_TVAL  in  XLEN  trap value.
- TRAP_ACK  out  1  request accepted this cycle.
- RET_REQ  in  2  00 none, 01 SRET, 11 MRET; held until RET_ACK.
- RET_ACK  out  1  return accepted this cycle.
- MSTATUS  in  XLEN  current mstatus read view.
- MEDELEG  in  XLEN  current medeleg.
- MTVEC, STVEC  in  XLEN  current trap vectors.
- MEPC, SEPC  in  XLEN  current exception PCs.
- PIPE_WCMD  in  2  pipeline CSR write command; 00 = none.
- PIPE_WA  in  12  pipeline CSR write address.
- PIPE_WD  in  XLEN  pipeline CSR write data.
- PIPE_WREADY  out  1  pipeline write is forwarded this cycle.
- CSR_WCMD  out  2  to CSR file; 00 none, 01 write.
- CSR_WA  out  12  to CSR file.
- CSR_WD  out  XLEN  to CSR file.
- MODE  out  2  current privilege: 00 U, 01 S, 11 M.
- REDIRECT  out  1  one-cycle PC redirect pulse.
- REDIRECT_PC  out  XLEN  redirect target.
- BUSY  out  1  state is not IDLE.

Behaviour:
- Reset values: state IDLE; MODE=11. TRAP_ACK, RET_ACK, REDIRECT, BUSY, PIPE_WREADY = 0; CSR_WCMD=00. RST mid-sequence aborts with no further writes and no redirect.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, R_STAT.
- IDLE, priority order:
  - TRAP_REQ: TRAP_ACK=1 (combinational). Capture cause/epc/tval, MSTATUS snapshot, target and target tvec. Go to T_EPC.
  - Else RET_REQ!=00: RET_ACK=1. Capture MSTATUS, kind, xEPC. Go to R_STAT.
  - Else: PIPE_WREADY=1 and PIPE_* pass straight to CSR_* (same cycle).
- In every non-IDLE state, and in any cycle with an ack, PIPE_WREADY=0 and the pipeline must hold its write.
- Trap target: S if MODE!=11 and MEDELEG[TRAP_CAUSE[5:0]]==1, else M.
  - x = s: addresses 141/142/143/100.
  - x = m: addresses 341/342/343/300.
- Trap sequence, one CSR write per cycle with CSR_WCMD=01:
  - T_EPC: xepc <- epc.
  - T_CAUSE: xcause <- cause.
  - T_TVAL: xtval <- tval.
  - T_STAT: xstatus <- updated snapshot; REDIRECT=1; REDIRECT_PC = {tvec[XLEN-1:2],2'b00}; MODE <= target at clock edge. Then IDLE.
  - Redirect occurs 4 cycles after ack.
- Status update, M target: MPIE<=MIE(bit3), MIE<=0, MPP[12:11]<=old MODE. All other bits unchanged.
- Status update, S target: SPIE<=SIE(bit1), SIE<=0, SPP[8]<=old MODE[0]. Write address 100.
- Returns, R_STAT: one write, REDIRECT=1, then IDLE.
  - MRET: mstatus: MIE<=MPIE, MPIE<=1, MPP<=00; MODE<=old MPP; REDIRECT_PC=MEPC.
  - SRET: sstatus: SIE<=SPIE, SPIE<=1, SPP<=0; MODE<={1'b0,old SPP}; REDIRECT_PC=SEPC.
- Simultaneous TRAP_REQ and RET_REQ in IDLE: trap wins; RET_REQ stays pending and is accepted in the first IDLE cycle after.
- A new request is never accepted in the cycle REDIRECT=1.
- Privilege legality of xRET is checked upstream; this block executes whatever is requested.
- MODE=11 and MPP=11 traps are legal (nested M trap).
- Snapshot inputs are sampled only at ack. Changes to MSTATUS/tvec/EPC inputs during a sequence are ignored.

Test Plan:
- Reset, then MODE=11, TRAP_REQ cause=2, epc=0x8000_0100, tval=0xDEAD, MTVEC=0x8000_0003, MSTATUS.MIE=1 -> ack at t0. Writes at t1..t4: 341=0x8000_0100, 342=2, 343=0xDEAD, 300 with MPIE=1, MIE=0, MPP=11. REDIRECT at t4 with PC 0x8000_0000.
- MODE=00, MEDELEG[8]=1, cause=8, STVEC=0x8020_0000, SIE=1 -> writes 141/142/143/100. 100 has SPIE=1, SIE=0, SPP=0. MODE=01 after t4; REDIRECT_PC=0x8020_0000.
- MODE=01, MEDELEG=0, cause=8 -> M target: addresses 341..300, MPP=01, MODE=11.
- MRET with MPP=01, MPIE=1, MEPC=0x8020_1000 -> one-cycle write to 300 with MIE=1, MPIE=1, MPP=00. REDIRECT at t1 with PC 0x8020_1000; MODE=01.
- TRAP_REQ, RET_REQ=01 and PIPE_WCMD=01 all in the same cycle -> TRAP_ACK only, PIPE_WREADY=0 for 5 cycles. SRET accepted in the first IDLE cycle after the trap redirect; the pipeline write is forwarded after the SRET completes.
- RST asserted during T_CAUSE -> no T_TVAL/T_STAT writes, no REDIRECT, MODE=11, IDLE next cycle.
